// File: rtl/led_pwm_pkg.sv
// Shared constants for the LED PWM driver: register map, CTRL field positions
// and the duty code that means "always on".
package led_pwm_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DUTY   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_BLINK  = 2'd3;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_PRESCALE_LSB = 16;

  localparam logic [7:0] DUTY_FULL = 8'hFF;

endpackage

// File: rtl/led_pwm_timebase.sv
// PWM timebase: a reloadable prescaler feeding an 8-bit PWM counter.
// Both counters clear synchronously whenever enable is low.
module led_pwm_timebase #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [7:0]            pwm_cnt,
  output logic                  tick,
  output logic                  period_end
);

  logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [7:0]            pwm_cnt_q, pwm_cnt_d;

  // A prescale lowered below the running count only matches again after wrap.
  always_comb begin
    tick        = enable && (presc_cnt_q == prescale);
    period_end  = tick && (pwm_cnt_q == 8'hFF);
    presc_cnt_d = presc_cnt_q + 1'b1;
    pwm_cnt_d   = pwm_cnt_q;
    if (!enable) begin
      presc_cnt_d = '0;
      pwm_cnt_d   = '0;
    end else if (tick) begin
      presc_cnt_d = '0;
      pwm_cnt_d   = pwm_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

  assign pwm_cnt = pwm_cnt_q;

endmodule

// File: rtl/led_pwm_driver.sv
// LED PWM driver with Avalon-MM register slave; pattern and duty are latched
// only at PWM period boundaries. Optional blink feature: LED_PWM_BLINK_EN.
module led_pwm_driver
  import led_pwm_pkg::*;
#(
  parameter int                    N_LEDS       = 8,
  parameter int                    PRESCALE_W   = 16,
  parameter logic [PRESCALE_W-1:0] PRESCALE_RST = PRESCALE_W'(195),
  parameter logic [7:0]            DUTY_RST     = 8'h80
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_LEDS-1:0] pattern_in,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [N_LEDS-1:0] led_out
);

  logic                  wr_en;
  logic                  enable_q, enable_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [7:0]            duty_q, duty_d;
  logic [N_LEDS-1:0]     pattern_act_q, pattern_act_d;
  logic [7:0]            duty_act_q, duty_act_d;
  logic [N_LEDS-1:0]     led_out_q, led_out_d;
  logic                  run;
  logic                  tick;
  logic                  period_end;
  logic                  boundary;
  logic [7:0]            pwm_cnt;
  logic                  duty_on;
  logic [N_LEDS-1:0]     blank;

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    enable_d   = enable_q;
    prescale_d = prescale_q;
    duty_d     = duty_q;
    if (wr_en) begin
      case (address)
        ADDR_CTRL: begin
          enable_d   = writedata[CTRL_ENABLE_BIT];
          prescale_d = writedata[CTRL_PRESCALE_LSB +: PRESCALE_W];
        end
        ADDR_DUTY: duty_d = writedata[7:0];
        default: ;
      endcase
    end
  end

  // A disabling write stops the timebase and blanks the LEDs on its own edge.
  assign run = enable_q & enable_d;

  led_pwm_timebase #(
    .PRESCALE_W (PRESCALE_W)
  ) u_timebase (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (run),
    .prescale   (prescale_q),
    .pwm_cnt    (pwm_cnt),
    .tick       (tick),
    .period_end (period_end)
  );

  assign boundary = tick & period_end;

  always_comb begin
    pattern_act_d = pattern_act_q;
    duty_act_d    = duty_act_q;
    if (!run || boundary) begin
      pattern_act_d = pattern_in;
      duty_act_d    = duty_q;
    end
  end

`ifdef LED_PWM_BLINK_EN
  logic [7:0] blink_mask_q, blink_mask_d;
  logic [7:0] blink_rate_q, blink_rate_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_phase_q, blink_phase_d;

  // blink_cnt counts whole PWM periods; the phase flips every 'rate' periods.
  always_comb begin
    blink_mask_d  = blink_mask_q;
    blink_rate_d  = blink_rate_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wr_en && (address == ADDR_BLINK)) begin
      blink_mask_d = writedata[7:0];
      blink_rate_d = writedata[15:8];
    end
    if (!run || (blink_rate_q == 8'd0)) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (boundary) begin
      if (blink_cnt_q == blink_rate_q - 8'd1) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_mask_q  <= '0;
      blink_rate_q  <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_mask_q  <= blink_mask_d;
      blink_rate_q  <= blink_rate_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blank = blink_phase_q ? blink_mask_q[N_LEDS-1:0] : '0;
`else
  assign blank = '0;
`endif

  always_comb begin
    duty_on   = (duty_act_q == DUTY_FULL) || (pwm_cnt < duty_act_q);
    led_out_d = '0;
    if (run) begin
      led_out_d = pattern_act_q & ~blank & {N_LEDS{duty_on}};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q      <= 1'b0;
      prescale_q    <= PRESCALE_RST;
      duty_q        <= DUTY_RST;
      pattern_act_q <= '0;
      duty_act_q    <= '0;
      led_out_q     <= '0;
    end else begin
      enable_q      <= enable_d;
      prescale_q    <= prescale_d;
      duty_q        <= duty_d;
      pattern_act_q <= pattern_act_d;
      duty_act_q    <= duty_act_d;
      led_out_q     <= led_out_d;
    end
  end

  assign led_out = led_out_q;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_ENABLE_BIT]                   = enable_q;
        readdata[CTRL_PRESCALE_LSB +: PRESCALE_W]   = prescale_q;
      end
      ADDR_DUTY:   readdata[7:0] = duty_q;
      ADDR_STATUS: begin
        readdata[7:0]         = pwm_cnt;
        readdata[8 +: N_LEDS] = pattern_act_q;
      end
`ifdef LED_PWM_BLINK_EN
      ADDR_BLINK: begin
        readdata[7:0]  = blink_mask_q;
        readdata[15:8] = blink_rate_q;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver: expected LED values are queued per clock
// and compared after the edge; register reads are checked directly.
module tb_led_pwm_driver;
  import led_pwm_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  pattern_in = 8'h00;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  led_out;

  int vecCount = 0;
  int missCount = 0;
  logic [7:0] sb[$];

  int         cyc = 0;
  logic [7:0] curPat = 8'h00;
  logic [7:0] dOld = 8'h00;
  logic [7:0] dNew = 8'h00;
  int         switchCyc = 1 << 30;
  logic [7:0] blinkMask = 8'h00;
  int         blinkRate = 0;

  led_pwm_driver dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pattern_in (pattern_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  // Expected LED value after the c-th edge since enable (reflects pwm_cnt c-1).
  function automatic logic [7:0] expLed(input int c);
    int         p;
    logic [7:0] d;
    logic [7:0] e;
    p = (c - 1) % 256;
    d = ((c - 1) < switchCyc) ? dOld : dNew;
    e = ((d == 8'hFF) || (p < int'(d))) ? curPat : 8'h00;
    if ((blinkRate != 0) && ((((c - 1) / (256 * blinkRate)) % 2) == 1))
      e = e & ~blinkMask;
    return e;
  endfunction

  task automatic checkOutput(input string tag);
    logic [7:0] exp;
    exp = sb.pop_front();
    vecCount++;
    assert (led_out === exp) else begin
      missCount++;
      $error("[TB] FAIL %s cyc=%0d: led_out=%h expected %h", tag, cyc, led_out, exp);
    end
  endtask

  task automatic readCheck(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    #1;
    vecCount++;
    assert (readdata === exp) else begin
      missCount++;
      $error("[TB] FAIL %s: readdata=%h expected %h", tag, readdata, exp);
    end
  endtask

  task automatic startWrite(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
  endtask

  task automatic endWrite();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic cpuWrite(input logic [1:0] a, input logic [31:0] d);
    startWrite(a, d);
    @(negedge clk);
    endWrite();
  endtask

  task automatic setMode(input logic [7:0] pat, input logic [7:0] d);
    curPat     = pat;
    pattern_in = pat;
    dOld       = d;
    dNew       = d;
    switchCyc  = 1 << 30;
  endtask

  // The enabling edge itself still drives LEDs off; counting starts after it.
  task automatic enableRun(input logic [31:0] ctrl);
    startWrite(ADDR_CTRL, ctrl);
    sb.push_back(8'h00);
    @(negedge clk);
    checkOutput("enable_edge");
    endWrite();
    cyc = 0;
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      cyc++;
      sb.push_back(expLed(cyc));
      @(negedge clk);
      checkOutput("led_pwm");
    end
  endtask

  initial begin
    $display("[TB] start");
    @(negedge clk);
    sb.push_back(8'h00);
    checkOutput("reset_led");
    readCheck(ADDR_CTRL,   32'h00C3_0000, "reset_ctrl");
    readCheck(ADDR_DUTY,   32'h0000_0080, "reset_duty");
    readCheck(ADDR_STATUS, 32'h0000_0000, "reset_status");
    readCheck(ADDR_BLINK,  32'h0000_0000, "reset_blink");
    @(negedge clk);
    reset_n = 1'b1;

    // duty 0x40 on pattern 0xA5: 64 clocks on, 192 off
    setMode(8'hA5, 8'h40);
    cpuWrite(ADDR_CTRL, 32'h0000_0000);
    cpuWrite(ADDR_DUTY, 32'h0000_0040);
    readCheck(ADDR_DUTY, 32'h0000_0040, "duty_rd");
    enableRun(32'h0000_0001);
    applyStimulus(512);
    readCheck(ADDR_STATUS, 32'h0000_A500, "status_a5");
    readCheck(ADDR_CTRL,   32'h0000_0001, "ctrl_en");

    setMode(8'hA5, 8'h00);
    cpuWrite(ADDR_CTRL, 32'h0000_0000);
    cpuWrite(ADDR_DUTY, 32'h0000_0000);
    enableRun(32'h0000_0001);
    applyStimulus(300);

    setMode(8'h3C, 8'hFF);
    cpuWrite(ADDR_CTRL, 32'h0000_0000);
    cpuWrite(ADDR_DUTY, 32'h0000_00FF);
    enableRun(32'h0000_0001);
    applyStimulus(300);

    // DUTY writes mid-period and on the period_end cycle
    setMode(8'h5A, 8'hC0);
    cpuWrite(ADDR_CTRL, 32'h0000_0000);
    cpuWrite(ADDR_DUTY, 32'h0000_00C0);
    enableRun(32'h0000_0001);
    applyStimulus(100);
    dNew      = 8'h20;
    switchCyc = 256;
    startWrite(ADDR_DUTY, 32'h0000_0020);
    applyStimulus(1);
    endWrite();
    applyStimulus(410);
    dOld      = 8'h20;
    dNew      = 8'h90;
    switchCyc = 768;
    startWrite(ADDR_DUTY, 32'h0000_0090);
    applyStimulus(1);
    endWrite();
    applyStimulus(300);

    // disable at pwm_cnt=37, then re-enable from zero
    setMode(8'hFF, 8'hFF);
    cpuWrite(ADDR_CTRL, 32'h0000_0000);
    cpuWrite(ADDR_DUTY, 32'h0000_00FF);
    enableRun(32'h0000_0001);
    applyStimulus(37);
    startWrite(ADDR_CTRL, 32'h0000_0000);
    sb.push_back(8'h00);
    @(negedge clk);
    checkOutput("disable_led");
    endWrite();
    readCheck(ADDR_STATUS, 32'h0000_FF00, "disable_status");
    enableRun(32'h0000_0001);
    applyStimulus(5);
    readCheck(ADDR_STATUS, 32'h0000_FF05, "reenable_status");

    // prescale 3: pwm_cnt advances every 4 clocks
    cpuWrite(ADDR_CTRL, 32'h0003_0000);
    enableRun(32'h0003_0001);
    repeat (10) @(negedge clk);
    readCheck(ADDR_STATUS, 32'h0000_FF02, "presc_status");
    readCheck(ADDR_CTRL,   32'h0003_0001, "presc_ctrl");
    sb.push_back(8'hFF);
    checkOutput("presc_led");

    // asynchronous reset while running
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    sb.push_back(8'h00);
    checkOutput("async_reset_led");
    readCheck(ADDR_CTRL,   32'h00C3_0000, "async_reset_ctrl");
    readCheck(ADDR_STATUS, 32'h0000_0000, "async_reset_status");
    @(negedge clk);
    reset_n = 1'b1;

    setMode(8'hFF, 8'hFF);
    cpuWrite(ADDR_CTRL, 32'h0000_0000);
    cpuWrite(ADDR_DUTY, 32'h0000_00FF);
`ifdef LED_PWM_BLINK_EN
    cpuWrite(ADDR_BLINK, 32'h0000_0201);
    readCheck(ADDR_BLINK, 32'h0000_0201, "blink_rd");
    blinkMask = 8'h01;
    blinkRate = 2;
    enableRun(32'h0000_0001);
    applyStimulus(1100);
`else
    cpuWrite(ADDR_BLINK, 32'h0000_0201);
    readCheck(ADDR_BLINK, 32'h0000_0000, "blink_absent");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
